// File: rtl/noc_vc_flit_arbiter.sv
// Round-robin virtual-channel flit arbiter with a registered output stage.
// Define NOC_VC_ARB_PACKET_LOCK_EN to hold a grant from head flit to tail flit; otherwise every flit is arbitrated.
module noc_vc_flit_arbiter #(
  parameter int CHANNELS   = 4,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                           noc_clk,
  input  logic                           noc_rst,
  input  logic                           i_clear,
  input  logic [CHANNELS-1:0]            i_valid,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
  output logic [CHANNELS-1:0]            o_ready,
  output logic                           o_valid,
  output logic [CHANNELS-1:0]            o_vc,
  output logic [FLIT_WIDTH-1:0]          o_flit,
  input  logic                           i_ready,
  input  logic [CHANNELS-1:0]            i_vc_ready,
  output logic                           o_locked
);

  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [FLIT_WIDTH-1:0] flit_arr [CHANNELS];
  logic [CHANNELS-1:0]   elig;
  logic [CHANNELS-1:0]   cand;
  logic                  found;
  logic [PW-1:0]         pick;
  int                    scan_idx;
  logic                  grant;
  logic [PW-1:0]         gnt_idx;
  logic [PW-1:0]         next_ptr;
  logic [CHANNELS-1:0]   gnt_onehot;
  logic [FLIT_WIDTH-1:0] sel_flit;
  logic                  load;
  logic                  pop;

  logic                  o_valid_reg;
  logic [CHANNELS-1:0]   o_vc_reg;
  logic [FLIT_WIDTH-1:0] o_flit_reg;
  logic [PW-1:0]         rr_ptr_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign flit_arr[gi] = i_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end
  endgenerate

  assign elig = i_valid & i_vc_ready;
  assign load = !o_valid_reg || i_ready;

  // First candidate at or after rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      scan_idx = int'(rr_ptr_reg) + k;
      if (scan_idx >= CHANNELS) scan_idx = scan_idx - CHANNELS;
      if (!found && cand[scan_idx[PW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[PW-1:0];
      end
    end
  end

`ifdef NOC_VC_ARB_PACKET_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state_reg;
  logic [PW-1:0]       owner_reg;
  logic                gap_reg;
  logic [CHANNELS-1:0] head_bits;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_head
      assign head_bits[gi] = flit_arr[gi][FLIT_WIDTH-1];
    end
  endgenerate

  // Only head flits may open a packet; a stray body flit waits untouched.
  assign cand = elig & head_bits;

  always_comb begin
    grant   = 1'b0;
    gnt_idx = pick;
    if (state_reg == LOCKED) begin
      grant   = elig[owner_reg];
      gnt_idx = owner_reg;
    end else begin
      grant   = found && !gap_reg;
    end
  end

  assign o_locked = (state_reg == LOCKED);
`else
  assign cand     = elig;
  assign grant    = found;
  assign gnt_idx  = pick;
  assign o_locked = 1'b0;
`endif

  assign sel_flit   = flit_arr[gnt_idx];
  assign gnt_onehot = CHANNELS'(1) << gnt_idx;
  assign next_ptr   = (gnt_idx == PW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
  assign pop        = load && grant && !noc_rst && !i_clear;
  assign o_ready    = pop ? gnt_onehot : '0;

  always_ff @(posedge noc_clk) begin
    if (noc_rst || i_clear) begin
      o_valid_reg <= 1'b0;
      o_vc_reg    <= '0;
      o_flit_reg  <= '0;
      rr_ptr_reg  <= '0;
`ifdef NOC_VC_ARB_PACKET_LOCK_EN
      state_reg   <= IDLE;
      owner_reg   <= '0;
      gap_reg     <= 1'b0;
`endif
    end else begin
      if (load) begin
        o_valid_reg <= pop;
        if (pop) begin
          o_flit_reg <= sel_flit;
          o_vc_reg   <= gnt_onehot;
        end
      end
`ifdef NOC_VC_ARB_PACKET_LOCK_EN
      if (state_reg == IDLE) begin
        // The gap flag burns exactly one load slot after a locked tail.
        if (load) gap_reg <= 1'b0;
        if (pop) begin
          rr_ptr_reg <= next_ptr;
          if (!sel_flit[FLIT_WIDTH-2]) begin
            state_reg <= LOCKED;
            owner_reg <= gnt_idx;
          end
        end
      end else if (pop && sel_flit[FLIT_WIDTH-2]) begin
        state_reg <= IDLE;
        gap_reg   <= 1'b1;
      end
`else
      if (pop) rr_ptr_reg <= next_ptr;
`endif
    end
  end

  assign o_valid = o_valid_reg;
  assign o_vc    = o_vc_reg;
  assign o_flit  = o_flit_reg;

endmodule

// File: tb/tb_noc_vc_flit_arbiter.sv
// Directed bench for noc_vc_flit_arbiter (CHANNELS=4, FLIT_WIDTH=8: bit7 head, bit6 tail).
// Per-VC queues stand in for the upstream FIFOs and pop on o_ready.
module tb_noc_vc_flit_arbiter;

  logic        noc_clk = 1'b0;
  logic        noc_rst;
  logic        i_clear;
  logic [3:0]  i_valid;
  logic [31:0] i_flit;
  logic [3:0]  o_ready;
  logic        o_valid;
  logic [3:0]  o_vc;
  logic [7:0]  o_flit;
  logic        i_ready;
  logic [3:0]  i_vc_ready;
  logic        o_locked;

  logic [7:0]  q [4][$];
  int          n_checks = 0;
  int          n_err    = 0;

`ifdef NOC_VC_ARB_PACKET_LOCK_EN
  localparam logic LK = 1'b1;
`else
  localparam logic LK = 1'b0;
`endif

  always #5 noc_clk = ~noc_clk;

  noc_vc_flit_arbiter #(.CHANNELS(4), .FLIT_WIDTH(8)) dut (
    .noc_clk(noc_clk), .noc_rst(noc_rst), .i_clear(i_clear),
    .i_valid(i_valid), .i_flit(i_flit), .o_ready(o_ready),
    .o_valid(o_valid), .o_vc(o_vc), .o_flit(o_flit),
    .i_ready(i_ready), .i_vc_ready(i_vc_ready), .o_locked(o_locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int v = 0; v < 4; v++) begin
      i_valid[v] = (q[v].size() > 0);
      i_flit[v*8 +: 8] = (q[v].size() > 0) ? q[v][0] : 8'h00;
    end
  endtask

  task automatic settle();
    drive();
    #1;
  endtask

  task automatic tick();
    logic [3:0] r;
    drive();
    #1;
    r = o_ready;
    @(posedge noc_clk);
    #1;
    for (int v = 0; v < 4; v++)
      if (r[v] && q[v].size() > 0) void'(q[v].pop_front());
    drive();
    #1;
    $display("[%0t] pop=%b out valid=%b vc=%b flit=%h locked=%b",
             $time, r, o_valid, o_vc, o_flit, o_locked);
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [3:0] vc,
                            input logic [7:0] f, input logic lk);
    chk({tag, "_valid"}, o_valid, v);
    if (v) begin
      chk({tag, "_vc"}, o_vc, vc);
      chk({tag, "_flit"}, o_flit, f);
    end
    chk({tag, "_locked"}, o_locked, lk);
  endtask

  initial begin
    noc_rst = 1'b1; i_clear = 1'b0; i_ready = 1'b1; i_vc_ready = 4'hF;
    i_valid = '0; i_flit = '0;

    // Reset with single-flit packets waiting on every VC
    for (int v = 0; v < 4; v++) q[v].push_back(8'hC0 | 8'(v));
    tick(); tick();
    settle();
    chk("rst_ready", o_ready, 4'b0000);
    chk("rst_vc", o_vc, 4'b0000);
    chk("rst_flit", o_flit, 8'h00);
    expect_out("rst", 1'b0, 4'b0000, 8'h00, 1'b0);
    noc_rst = 1'b0;
    settle();
    chk("rr_ready0", o_ready, 4'b0001);
    tick(); expect_out("rr0", 1'b1, 4'b0001, 8'hC0, 1'b0);
    chk("rr_ready1", o_ready, 4'b0010);
    tick(); expect_out("rr1", 1'b1, 4'b0010, 8'hC1, 1'b0);
    tick(); expect_out("rr2", 1'b1, 4'b0100, 8'hC2, 1'b0);
    tick(); expect_out("rr3", 1'b1, 4'b1000, 8'hC3, 1'b0);
    tick(); expect_out("rr_idle", 1'b0, 4'b0000, 8'h00, 1'b0);

`ifdef NOC_VC_ARB_PACKET_LOCK_EN
    // 4-flit packet on VC1 while VC2 holds a head
    q[1].push_back(8'h81); q[1].push_back(8'h02); q[1].push_back(8'h03); q[1].push_back(8'h44);
    q[2].push_back(8'hC5);
    settle();
    chk("pk_ready0", o_ready, 4'b0010);
    tick(); expect_out("pk0", 1'b1, 4'b0010, 8'h81, 1'b1);
    tick(); expect_out("pk1", 1'b1, 4'b0010, 8'h02, 1'b1);
    tick(); expect_out("pk2", 1'b1, 4'b0010, 8'h03, 1'b1);
    tick(); expect_out("pk3", 1'b1, 4'b0010, 8'h44, 1'b0);
    chk("pk_gap_ready", o_ready, 4'b0000);
    tick(); expect_out("pk_bubble", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("pk_vc2_ready", o_ready, 4'b0100);
    tick(); expect_out("pk_vc2", 1'b1, 4'b0100, 8'hC5, 1'b0);
    tick(); expect_out("pk_idle", 1'b0, 4'b0000, 8'h00, 1'b0);

    // Owner VC3 loses credit mid-packet while VC0 is eligible
    q[3].push_back(8'hA3); q[3].push_back(8'h13); q[3].push_back(8'h53);
    q[0].push_back(8'hC0);
    settle();
    chk("cr_ready0", o_ready, 4'b1000);
    tick(); expect_out("cr0", 1'b1, 4'b1000, 8'hA3, 1'b1);
    i_vc_ready = 4'b0111;
    settle();
    chk("cr_hold_ready0", o_ready, 4'b0000);
    tick(); expect_out("cr_stall0", 1'b0, 4'b0000, 8'h00, 1'b1);
    chk("cr_hold_ready1", o_ready, 4'b0000);
    tick(); expect_out("cr_stall1", 1'b0, 4'b0000, 8'h00, 1'b1);
    i_vc_ready = 4'hF;
    settle();
    chk("cr_resume_ready", o_ready, 4'b1000);
    tick(); expect_out("cr1", 1'b1, 4'b1000, 8'h13, 1'b1);
    tick(); expect_out("cr2", 1'b1, 4'b1000, 8'h53, 1'b0);
    chk("cr_gap_ready", o_ready, 4'b0000);
    tick(); expect_out("cr_bubble", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("cr_vc0_ready", o_ready, 4'b0001);
    tick(); expect_out("cr_vc0", 1'b1, 4'b0001, 8'hC0, 1'b0);
    tick(); expect_out("cr_idle", 1'b0, 4'b0000, 8'h00, 1'b0);

    // Clear after 2 of 5 flits of a VC1 packet; rr_ptr must return to 0
    q[1].push_back(8'h81); q[1].push_back(8'h02); q[1].push_back(8'h03);
    q[1].push_back(8'h04); q[1].push_back(8'h45);
    q[0].push_back(8'hC0);
    q[2].push_back(8'hC6);
    settle();
    chk("cl_ready0", o_ready, 4'b0010);
    tick(); expect_out("cl0", 1'b1, 4'b0010, 8'h81, 1'b1);
    tick(); expect_out("cl1", 1'b1, 4'b0010, 8'h02, 1'b1);
    i_clear = 1'b1;
    settle();
    chk("cl_ready_clr", o_ready, 4'b0000);
    tick();
    i_clear = 1'b0;
    expect_out("cl_flush", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("cl_vc", o_vc, 4'b0000);
    chk("cl_flit", o_flit, 8'h00);
    settle();
    chk("cl_rr_ready", o_ready, 4'b0001);
    tick(); expect_out("cl_vc0", 1'b1, 4'b0001, 8'hC0, 1'b0);
    tick(); expect_out("cl_vc2", 1'b1, 4'b0100, 8'hC6, 1'b0);
    tick(); expect_out("cl_stuck", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("cl_body_not_granted", o_ready, 4'b0000);
    q[1].delete();
`else
    // Per-flit interleave of two 3-flit packets
    q[0].push_back(8'h81); q[0].push_back(8'h02); q[0].push_back(8'h43);
    q[1].push_back(8'h91); q[1].push_back(8'h12); q[1].push_back(8'h53);
    settle();
    chk("il_ready0", o_ready, 4'b0001);
    tick(); expect_out("il0", 1'b1, 4'b0001, 8'h81, 1'b0);
    chk("il_ready1", o_ready, 4'b0010);
    tick(); expect_out("il1", 1'b1, 4'b0010, 8'h91, 1'b0);
    tick(); expect_out("il2", 1'b1, 4'b0001, 8'h02, 1'b0);
    tick(); expect_out("il3", 1'b1, 4'b0010, 8'h12, 1'b0);
    tick(); expect_out("il4", 1'b1, 4'b0001, 8'h43, 1'b0);
    tick(); expect_out("il5", 1'b1, 4'b0010, 8'h53, 1'b0);
    tick(); expect_out("il_idle", 1'b0, 4'b0000, 8'h00, 1'b0);

    // Clear mid-stream; rr_ptr must restart at 0
    q[2].push_back(8'h86); q[2].push_back(8'h07);
    tick(); expect_out("cl0", 1'b1, 4'b0100, 8'h86, 1'b0);
    q[3].push_back(8'hC3); q[0].push_back(8'hC0);
    i_clear = 1'b1;
    settle();
    chk("cl_ready_clr", o_ready, 4'b0000);
    tick();
    i_clear = 1'b0;
    expect_out("cl_flush", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("cl_vc", o_vc, 4'b0000);
    chk("cl_flit", o_flit, 8'h00);
    settle();
    chk("cl_rr_ready", o_ready, 4'b0001);
    tick(); expect_out("cl_vc0", 1'b1, 4'b0001, 8'hC0, 1'b0);
    tick(); expect_out("cl_vc2", 1'b1, 4'b0100, 8'h07, 1'b0);
    tick(); expect_out("cl_vc3", 1'b1, 4'b1000, 8'hC3, 1'b0);
    tick(); expect_out("cl_idle", 1'b0, 4'b0000, 8'h00, 1'b0);
`endif

    // Downstream back-pressure mid-packet on VC0
    q[0].push_back(8'h8A); q[0].push_back(8'h0B); q[0].push_back(8'h0C); q[0].push_back(8'h4D);
    settle();
    chk("bp_ready0", o_ready, 4'b0001);
    tick(); expect_out("bp0", 1'b1, 4'b0001, 8'h8A, LK);
    tick(); expect_out("bp1", 1'b1, 4'b0001, 8'h0B, LK);
    i_ready = 1'b0;
    settle();
    chk("bp_ready_hold", o_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out("bp_hold", 1'b1, 4'b0001, 8'h0B, LK);
      chk("bp_hold_ready", o_ready, 4'b0000);
    end
    i_ready = 1'b1;
    settle();
    chk("bp_resume_ready", o_ready, 4'b0001);
    tick(); expect_out("bp2", 1'b1, 4'b0001, 8'h0C, LK);
    tick(); expect_out("bp3", 1'b1, 4'b0001, 8'h4D, 1'b0);
    tick(); expect_out("bp_idle", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("bp_fifo_drained", 32'(q[0].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
